// File: rtl/alu_issue_stage_if.sv
// ID/EX issue-stage bundle: decoder-side request, forwarding taps, ALU-side response.
// Combinational wiring only; no latency of its own.
// Backpressure travels as in_ready (to the decoder) and out_ready (from the ALU).
interface alu_issue_stage_if #(
  parameter int word_size      = 16,
  parameter int reg_addr_width = 3
);
  logic                      flush;
  logic                      in_valid;
  logic                      in_ready;
  logic [1:0]                in_operation;
  logic [reg_addr_width-1:0] in_rs1;
  logic [reg_addr_width-1:0] in_rs2;
  logic [word_size-1:0]      in_rs1_data;
  logic [word_size-1:0]      in_rs2_data;
  logic [word_size-1:0]      in_imm;
  logic                      in_use_imm;
  logic [reg_addr_width-1:0] in_rd;
  logic                      in_reg_write;
  logic                      in_mem_read;
  logic                      ex_fwd_valid;
  logic [reg_addr_width-1:0] ex_fwd_rd;
  logic [word_size-1:0]      ex_fwd_data;
  logic                      ex_fwd_is_load;
  logic                      wb_fwd_valid;
  logic [reg_addr_width-1:0] wb_fwd_rd;
  logic [word_size-1:0]      wb_fwd_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [1:0]                out_operation;
  logic [word_size-1:0]      out_operandA;
  logic [word_size-1:0]      out_operandB;
  logic [word_size-1:0]      out_store_data;
  logic [reg_addr_width-1:0] out_rd;
  logic                      out_reg_write;
  logic                      out_mem_read;
  logic [15:0]               stall_count;

  modport master (
    output flush, in_valid, in_operation, in_rs1, in_rs2, in_rs1_data, in_rs2_data,
           in_imm, in_use_imm, in_rd, in_reg_write, in_mem_read,
           ex_fwd_valid, ex_fwd_rd, ex_fwd_data, ex_fwd_is_load,
           wb_fwd_valid, wb_fwd_rd, wb_fwd_data, out_ready,
    input  in_ready, out_valid, out_operation, out_operandA, out_operandB,
           out_store_data, out_rd, out_reg_write, out_mem_read, stall_count
  );

  modport slave (
    input  flush, in_valid, in_operation, in_rs1, in_rs2, in_rs1_data, in_rs2_data,
           in_imm, in_use_imm, in_rd, in_reg_write, in_mem_read,
           ex_fwd_valid, ex_fwd_rd, ex_fwd_data, ex_fwd_is_load,
           wb_fwd_valid, wb_fwd_rd, wb_fwd_data, out_ready,
    output in_ready, out_valid, out_operation, out_operandA, out_operandB,
           out_store_data, out_rd, out_reg_write, out_mem_read, stall_count
  );
endinterface

// File: rtl/alu_issue_stage.sv
// ID/EX register: resolves operands with EX/WB forwarding and feeds the 16-bit ALU.
// Latency 1 cycle from capture to outputs; a full-throughput skid-less register.
// Backpressure: in_ready drops on held-and-stalled output, load-use hazard or flush.
module alu_issue_stage #(
  parameter int word_size      = 16,
  parameter int reg_addr_width = 3
) (
  input logic               clk,
  input logic               rst_n,
  alu_issue_stage_if.slave  bus
);

  logic                      w_hazard;
  logic                      w_in_ready;
  logic                      w_capture;
  logic [word_size-1:0]      w_fwd_rs1;
  logic [word_size-1:0]      w_fwd_rs2;
  logic [word_size-1:0]      w_operand_b;

  logic                      r_valid;
  logic [1:0]                r_operation;
  logic [word_size-1:0]      r_operand_a;
  logic [word_size-1:0]      r_operand_b;
  logic [word_size-1:0]      r_store_data;
  logic [reg_addr_width-1:0] r_rd;
  logic                      r_reg_write;
  logic                      r_mem_read;
  logic [15:0]               r_stall_count;

  // Operand resolution: x0 is hard zero, a load in EX has no data yet, EX beats WB.
  function automatic logic [word_size-1:0] resolve(
    input logic [reg_addr_width-1:0] rs,
    input logic [word_size-1:0]      rf_data,
    input logic                      ex_valid,
    input logic                      ex_is_load,
    input logic [reg_addr_width-1:0] ex_rd,
    input logic [word_size-1:0]      ex_data,
    input logic                      wb_valid,
    input logic [reg_addr_width-1:0] wb_rd,
    input logic [word_size-1:0]      wb_data
  );
    logic [word_size-1:0] v;
    if (rs == '0)                                        v = '0;
    else if (ex_valid && !ex_is_load && ex_rd == rs)     v = ex_data;
    else if (wb_valid && wb_rd == rs)                    v = wb_data;
    else                                                 v = rf_data;
    return v;
  endfunction

  // Forwarded source values for both operands.
  always_comb begin
    w_fwd_rs1 = resolve(bus.in_rs1, bus.in_rs1_data, bus.ex_fwd_valid, bus.ex_fwd_is_load,
                        bus.ex_fwd_rd, bus.ex_fwd_data, bus.wb_fwd_valid, bus.wb_fwd_rd,
                        bus.wb_fwd_data);
    w_fwd_rs2 = resolve(bus.in_rs2, bus.in_rs2_data, bus.ex_fwd_valid, bus.ex_fwd_is_load,
                        bus.ex_fwd_rd, bus.ex_fwd_data, bus.wb_fwd_valid, bus.wb_fwd_rd,
                        bus.wb_fwd_data);
    w_operand_b = bus.in_use_imm ? bus.in_imm : w_fwd_rs2;
  end

  // Load-use hazard: the load's data only exists after EX, so the consumer must wait.
  always_comb begin
    w_hazard = 1'b0;
    if (bus.in_valid && bus.ex_fwd_valid && bus.ex_fwd_is_load && bus.ex_fwd_rd != '0) begin
      if (bus.ex_fwd_rd == bus.in_rs1)                       w_hazard = 1'b1;
      if (bus.ex_fwd_rd == bus.in_rs2 && !bus.in_use_imm)   w_hazard = 1'b1;
    end
  end

  assign w_in_ready = (!r_valid || bus.out_ready) && !w_hazard && !bus.flush;
  assign w_capture  = bus.in_valid && w_in_ready;

  // Valid bit: flush wins, then a capture refills, else a consumed entry becomes a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             r_valid <= 1'b0;
    else if (bus.flush)     r_valid <= 1'b0;
    else if (w_capture)     r_valid <= 1'b1;
    else if (bus.out_ready) r_valid <= 1'b0;
  end

  // Payload only loads on capture, so a held entry is frozen including its forwarded values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_operation  <= 2'b00;
      r_operand_a  <= '0;
      r_operand_b  <= '0;
      r_store_data <= '0;
      r_rd         <= '0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
    end else if (w_capture) begin
      r_operation  <= bus.in_operation;
      r_operand_a  <= w_fwd_rs1;
      r_operand_b  <= w_operand_b;
      r_store_data <= w_fwd_rs2;
      r_rd         <= bus.in_rd;
      r_reg_write  <= bus.in_reg_write;
      r_mem_read   <= bus.in_mem_read;
    end
  end

  // Saturating count of load-use stall cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               r_stall_count <= '0;
    else if (w_hazard && r_stall_count != '1) r_stall_count <= r_stall_count + 16'd1;
  end

  assign bus.in_ready       = w_in_ready;
  assign bus.out_valid      = r_valid;
  assign bus.out_operation  = r_operation;
  assign bus.out_operandA   = r_operand_a;
  assign bus.out_operandB   = r_operand_b;
  assign bus.out_store_data = r_store_data;
  assign bus.out_rd         = r_rd;
  assign bus.out_reg_write  = r_reg_write;
  assign bus.out_mem_read   = r_mem_read;
  assign bus.stall_count    = r_stall_count;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a scoreboard queue and a separate output monitor.
// Expected transactions are hand-computed and pushed at issue; the monitor pops on consumption.
// Direct checks cover handshake, hold stability, stall counting, flush and async reset.
module tb_alu_issue_stage;

  typedef struct packed {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] sd;
    logic [2:0]  rd;
    logic        rw;
    logic        mr;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  exp_t sb_q[$];

  alu_issue_stage_if bus ();

  alu_issue_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [2:0] rs1, input logic [2:0] rs2,
                       input logic [15:0] d1, input logic [15:0] d2, input logic [15:0] imm,
                       input logic ui, input logic [2:0] rd, input logic rw, input logic mr);
    bus.in_valid     = 1'b1;
    bus.in_operation = op;
    bus.in_rs1       = rs1;
    bus.in_rs2       = rs2;
    bus.in_rs1_data  = d1;
    bus.in_rs2_data  = d2;
    bus.in_imm       = imm;
    bus.in_use_imm   = ui;
    bus.in_rd        = rd;
    bus.in_reg_write = rw;
    bus.in_mem_read  = mr;
  endtask

  task automatic set_ex(input logic v, input logic [2:0] rd, input logic [15:0] d, input logic ld);
    bus.ex_fwd_valid   = v;
    bus.ex_fwd_rd      = rd;
    bus.ex_fwd_data    = d;
    bus.ex_fwd_is_load = ld;
  endtask

  task automatic set_wb(input logic v, input logic [2:0] rd, input logic [15:0] d);
    bus.wb_fwd_valid = v;
    bus.wb_fwd_rd    = rd;
    bus.wb_fwd_data  = d;
  endtask

  task automatic push(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] sd, input logic [2:0] rd, input logic rw, input logic mr);
    exp_t e;
    e.op = op; e.a = a; e.b = b; e.sd = sd; e.rd = rd; e.rw = rw; e.mr = mr;
    sb_q.push_back(e);
  endtask

  // Monitor: a transaction is consumed when out_valid && out_ready at the next rising edge.
  initial begin
    exp_t e;
    exp_t act;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        act.op = bus.out_operation;  act.a  = bus.out_operandA;  act.b  = bus.out_operandB;
        act.sd = bus.out_store_data; act.rd = bus.out_rd;
        act.rw = bus.out_reg_write;  act.mr = bus.out_mem_read;
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected: got op=%h a=%h b=%h sd=%h rd=%h with empty queue at %0t",
                   act.op, act.a, act.b, act.sd, act.rd, $time);
        end else begin
          e = sb_q.pop_front();
          if (act !== e) begin
            failures++;
            $display("FAIL sb_txn: got op=%h a=%h b=%h sd=%h rd=%h rw=%b mr=%b expected op=%h a=%h b=%h sd=%h rd=%h rw=%b mr=%b at %0t",
                     act.op, act.a, act.b, act.sd, act.rd, act.rw, act.mr,
                     e.op, e.a, e.b, e.sd, e.rd, e.rw, e.mr, $time);
          end
        end
      end
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    issue(2'b00, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0, 1'b0, 3'd0, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    set_ex(1'b0, 3'd0, 16'h0, 1'b0);
    set_wb(1'b0, 3'd0, 16'h0);

    // Reset state
    #3;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_operation", 32'(bus.out_operation), 32'd0);
    chk("rst_operandA", 32'(bus.out_operandA), 32'd0);
    chk("rst_store_data", 32'(bus.out_store_data), 32'd0);
    chk("rst_stall_count", 32'(bus.stall_count), 32'd0);
    #9 rst_n = 1'b1;
    tick();

    // Back-to-back issue and forwarding priority
    bus.out_ready = 1'b1;
    issue(2'b00, 3'd1, 3'd2, 16'h0005, 16'h0003, 16'h0, 1'b0, 3'd4, 1'b1, 1'b0);
    #1 chk("b2b_in_ready", 32'(bus.in_ready), 32'd1);
    push(2'b00, 16'h0005, 16'h0003, 16'h0003, 3'd4, 1'b1, 1'b0);
    tick();
    chk("b2b_valid1", 32'(bus.out_valid), 32'd1);
    issue(2'b01, 3'd1, 3'd2, 16'h0005, 16'h0003, 16'h0, 1'b0, 3'd5, 1'b1, 1'b0);
    set_ex(1'b1, 3'd1, 16'h0010, 1'b0);
    set_wb(1'b1, 3'd1, 16'h0020);
    push(2'b01, 16'h0010, 16'h0003, 16'h0003, 3'd5, 1'b1, 1'b0);
    tick();
    // WB used when EX does not match
    issue(2'b10, 3'd2, 3'd1, 16'h0009, 16'h0007, 16'h0, 1'b0, 3'd6, 1'b0, 1'b1);
    set_ex(1'b1, 3'd3, 16'h0010, 1'b0);
    set_wb(1'b1, 3'd2, 16'h0020);
    push(2'b10, 16'h0020, 16'h0007, 16'h0007, 3'd6, 1'b0, 1'b1);
    tick();
    // x0 never forwarded; immediate selects operandB
    issue(2'b11, 3'd0, 3'd0, 16'h1234, 16'h4321, 16'hFFFE, 1'b1, 3'd1, 1'b1, 1'b0);
    set_ex(1'b1, 3'd0, 16'hFFFF, 1'b0);
    set_wb(1'b0, 3'd0, 16'h0);
    push(2'b11, 16'h0000, 16'hFFFE, 16'h0000, 3'd1, 1'b1, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    set_ex(1'b0, 3'd0, 16'h0, 1'b0);
    tick();
    chk("drain_bubble", 32'(bus.out_valid), 32'd0);

    // Load-use stall on rs2 for two cycles
    issue(2'b00, 3'd1, 3'd3, 16'h0011, 16'h0022, 16'h0, 1'b0, 3'd2, 1'b1, 1'b0);
    set_ex(1'b1, 3'd3, 16'hDEAD, 1'b1);
    #1 chk("lu_in_ready0", 32'(bus.in_ready), 32'd0);
    tick();
    chk("lu_bubble1", 32'(bus.out_valid), 32'd0);
    chk("lu_in_ready1", 32'(bus.in_ready), 32'd0);
    tick();
    chk("lu_bubble2", 32'(bus.out_valid), 32'd0);
    chk("lu_stall_count", 32'(bus.stall_count), 32'd2);
    set_ex(1'b0, 3'd0, 16'h0, 1'b0);
    push(2'b00, 16'h0011, 16'h0022, 16'h0022, 3'd2, 1'b1, 1'b0);
    tick();
    // Same load with immediate form: rs2 unused, no stall, store data not forwarded from load
    issue(2'b01, 3'd1, 3'd3, 16'h0011, 16'h0022, 16'h0040, 1'b1, 3'd3, 1'b1, 1'b0);
    set_ex(1'b1, 3'd3, 16'hDEAD, 1'b1);
    #1 chk("lu_imm_in_ready", 32'(bus.in_ready), 32'd1);
    push(2'b01, 16'h0011, 16'h0040, 16'h0022, 3'd3, 1'b1, 1'b0);
    tick();
    chk("lu_imm_stall_count", 32'(bus.stall_count), 32'd2);
    bus.in_valid = 1'b0;
    set_ex(1'b0, 3'd0, 16'h0, 1'b0);
    tick();

    // Backpressure: held entry stays stable, next instruction waits
    bus.out_ready = 1'b0;
    issue(2'b10, 3'd4, 3'd5, 16'h0F0F, 16'h00FF, 16'h0, 1'b0, 3'd7, 1'b1, 1'b0);
    push(2'b10, 16'h0F0F, 16'h00FF, 16'h00FF, 3'd7, 1'b1, 1'b0);
    tick();
    issue(2'b11, 3'd6, 3'd0, 16'h1000, 16'h5555, 16'h0, 1'b0, 3'd1, 1'b1, 1'b0);
    set_wb(1'b1, 3'd4, 16'hBEEF);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_operandA", 32'(bus.out_operandA), 32'h0F0F);
      chk("bp_operandB", 32'(bus.out_operandB), 32'h00FF);
      tick();
    end
    set_wb(1'b0, 3'd0, 16'h0);
    bus.out_ready = 1'b1;
    #1 chk("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
    push(2'b11, 16'h1000, 16'h0000, 16'h0000, 3'd1, 1'b1, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    chk("bp_new_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_new_rd", 32'(bus.out_rd), 32'd1);
    tick();
    tick();

    // Flush kills held entry and a same-cycle capture
    bus.out_ready = 1'b0;
    issue(2'b00, 3'd1, 3'd2, 16'h0101, 16'h0202, 16'h0, 1'b0, 3'd2, 1'b1, 1'b0);
    tick();
    chk("fl_held", 32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b1;
    bus.flush = 1'b1;
    issue(2'b01, 3'd3, 3'd4, 16'h0303, 16'h0404, 16'h0, 1'b0, 3'd3, 1'b1, 1'b0);
    #1 chk("fl_in_ready", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b0;
    tick();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("fl_valid", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b1;
    tick();
    chk("fl_not_captured", 32'(bus.out_valid), 32'd0);

    // Asynchronous reset during a hold
    bus.out_ready = 1'b0;
    issue(2'b10, 3'd5, 3'd6, 16'h0A0A, 16'h0B0B, 16'h0, 1'b0, 3'd4, 1'b1, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    chk("ar_held", 32'(bus.out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(bus.out_valid), 32'd0);
    chk("ar_stall_count", 32'(bus.stall_count), 32'd0);
    chk("ar_operandA", 32'(bus.out_operandA), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("ar_after_valid", 32'(bus.out_valid), 32'd0);

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
